// File: rtl/master_request_arbiter.sv
// master_request_arbiter
//   Shares a single master_transactor request path among C_NUM_REQ requesters.
//   A round-robin search picks one pending request. Its address, length and type
//   are latched and then issued as a provided-parameter transactor request. The
//   grant is held until the transactor reports completion, and completion is then
//   pulsed back to the winner. Only one transaction is in flight at a time.
//
//   Optional feature: define MASTER_ARB_TIMEOUT_EN to enable a watchdog in
//   ST_WAIT_DONE. When the watchdog expires, the transaction is aborted with
//   req_done + req_error.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req_valid[N]                  request pending (held until req_accept)
//   req_accept[N]                 1-cycle pulse: request latched
//   req_address/length/type       flattened per-requester request fields
//   req_done[N], req_error        1-cycle completion pulse to winner, abort flag
//   grant_id                      index of current/last winner
//   busy                          arbiter not idle
//   transactor_request            1-cycle issue pulse, with use_provided_param
//   provided_parameters_*         latched fields, valid with transactor_request
//   provided_request_type_r       latched type, valid with transactor_request
//   transactor_request_busy       transactor cannot accept a request
//   transaction_request_complete  transactor finished the request
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | arbitrate among pending requests
// ST_ISSUE     | request latched, waiting for transactor to be free
// ST_WAIT_DONE | request issued, waiting for transaction_request_complete

module master_request_arbiter #(
    parameter int C_NUM_REQ        = 4,
    parameter int C_ID_WIDTH       = 2,
    parameter int C_TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [C_NUM_REQ-1:0]      req_valid,
    output logic [C_NUM_REQ-1:0]      req_accept,
    input  logic [C_NUM_REQ*64-1:0]   req_address,
    input  logic [C_NUM_REQ*36-1:0]   req_length,
    input  logic [C_NUM_REQ*4-1:0]    req_type,
    output logic [C_NUM_REQ-1:0]      req_done,
    output logic                      req_error,
    output logic [C_ID_WIDTH-1:0]     grant_id,
    output logic                      busy,
    output logic                      transactor_request,
    output logic                      use_provided_param,
    output logic [35:0]               provided_parameters_length,
    output logic [3:0]                provided_request_type_r,
    output logic [63:0]               provided_parameters_address,
    input  logic                      transactor_request_busy,
    input  logic                      transaction_request_complete
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [C_ID_WIDTH-1:0]   rr_ptr;
    logic [63:0]             lat_address;
    logic [35:0]             lat_length;
    logic [3:0]              lat_type;

    logic                    found;
    logic [C_ID_WIDTH-1:0]   winner;
    logic [C_ID_WIDTH-1:0]   idx;
    logic [63:0]             sel_address;
    logic [35:0]             sel_length;
    logic [3:0]              sel_type;

    // Search starts one past the last winner so every agent gets a turn.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 1; i <= C_NUM_REQ; i++) begin
            idx = C_ID_WIDTH'((int'(rr_ptr) + i) % C_NUM_REQ);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        sel_address = '0;
        sel_length  = '0;
        sel_type    = '0;
        for (int j = 0; j < C_NUM_REQ; j++) begin
            if (C_ID_WIDTH'(j) == winner) begin
                sel_address = req_address[64*j +: 64];
                sel_length  = req_length[36*j +: 36];
                sel_type    = req_type[4*j +: 4];
            end
        end
    end

`ifdef MASTER_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(C_TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] wait_cnt;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^C_TIMEOUT_CYCLES;
`endif

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state                       <= ST_IDLE;
            rr_ptr                      <= C_ID_WIDTH'(C_NUM_REQ - 1);
            grant_id                    <= '0;
            lat_address                 <= '0;
            lat_length                  <= '0;
            lat_type                    <= '0;
            req_accept                  <= '0;
            req_done                    <= '0;
            req_error                   <= 1'b0;
            transactor_request          <= 1'b0;
            use_provided_param          <= 1'b0;
            provided_parameters_length  <= '0;
            provided_request_type_r     <= '0;
            provided_parameters_address <= '0;
`ifdef MASTER_ARB_TIMEOUT_EN
            wait_cnt                    <= '0;
`endif
        end else begin
            // Pulse outputs default low; provided_* are only non-zero on issue.
            req_accept                  <= '0;
            req_done                    <= '0;
            req_error                   <= 1'b0;
            transactor_request          <= 1'b0;
            use_provided_param          <= 1'b0;
            provided_parameters_length  <= '0;
            provided_request_type_r     <= '0;
            provided_parameters_address <= '0;

            case (state)
                ST_IDLE: begin
                    // Hold off one cycle while req_done is showing, so the
                    // next arbitration starts the cycle after completion.
                    if (found && (req_done == '0)) begin
                        req_accept[winner] <= 1'b1;
                        grant_id           <= winner;
                        lat_address        <= sel_address;
                        lat_length         <= sel_length;
                        lat_type           <= sel_type;
                        state              <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (lat_length == '0) begin
                        req_done[grant_id] <= 1'b1;
                        rr_ptr             <= grant_id;
                        state              <= ST_IDLE;
                    end else if (!transactor_request_busy) begin
                        transactor_request          <= 1'b1;
                        use_provided_param          <= 1'b1;
                        provided_parameters_length  <= lat_length;
                        provided_request_type_r     <= lat_type;
                        provided_parameters_address <= lat_address;
`ifdef MASTER_ARB_TIMEOUT_EN
                        wait_cnt                    <= '0;
`endif
                        state                       <= ST_WAIT_DONE;
                    end
                end

                ST_WAIT_DONE: begin
                    if (transaction_request_complete) begin
                        req_done[grant_id] <= 1'b1;
                        rr_ptr             <= grant_id;
                        state              <= ST_IDLE;
`ifdef MASTER_ARB_TIMEOUT_EN
                    end else if (wait_cnt == TMR_W'(C_TIMEOUT_CYCLES - 1)) begin
                        req_done[grant_id] <= 1'b1;
                        req_error          <= 1'b1;
                        rr_ptr             <= grant_id;
                        state              <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_master_request_arbiter.sv
module tb_master_request_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_accept;
    logic [N*64-1:0] req_address;
    logic [N*36-1:0] req_length;
    logic [N*4-1:0]  req_type;
    logic [N-1:0]    req_done;
    logic            req_error;
    logic [IW-1:0]   grant_id;
    logic            busy;
    logic            transactor_request;
    logic            use_provided_param;
    logic [35:0]     provided_parameters_length;
    logic [3:0]      provided_request_type_r;
    logic [63:0]     provided_parameters_address;
    logic            transactor_request_busy;
    logic            transaction_request_complete;

    logic [63:0] addr_t [N];
    logic [35:0] len_t  [N];
    logic [3:0]  typ_t  [N];

    assign req_address = {addr_t[3], addr_t[2], addr_t[1], addr_t[0]};
    assign req_length  = {len_t[3],  len_t[2],  len_t[1],  len_t[0]};
    assign req_type    = {typ_t[3],  typ_t[2],  typ_t[1],  typ_t[0]};

    always #5 clk = ~clk;

    master_request_arbiter #(
        .C_NUM_REQ(N), .C_ID_WIDTH(IW), .C_TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_accept(req_accept),
        .req_address(req_address), .req_length(req_length), .req_type(req_type),
        .req_done(req_done), .req_error(req_error), .grant_id(grant_id), .busy(busy),
        .transactor_request(transactor_request), .use_provided_param(use_provided_param),
        .provided_parameters_length(provided_parameters_length),
        .provided_request_type_r(provided_request_type_r),
        .provided_parameters_address(provided_parameters_address),
        .transactor_request_busy(transactor_request_busy),
        .transaction_request_complete(transaction_request_complete)
    );

    typedef struct {
        int          id;
        logic [63:0] addr;
        logic [35:0] len;
        logic [3:0]  typ;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int id);
        exp_t e;
        e.id   = id;
        e.addr = addr_t[id];
        e.len  = len_t[id];
        e.typ  = typ_t[id];
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Wait (bounded) for an issue pulse and compare it against the scoreboard head.
    // Any accept seen on the way must be for the expected winner; its request is
    // left asserted when keep is set (continuous requester), else withdrawn.
    task automatic wait_issue(input string tag, input bit keep);
        exp_t e;
        bit   seen = 0;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (req_accept != '0) begin
                chk({tag, "_accept"}, 64'(req_accept), 64'(N'(1) << e.id));
                if (!keep) req_valid = req_valid & ~req_accept;
            end
            if (transactor_request) seen = 1;
        end
        chk({tag, "_issue_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            chk({tag, "_grant"}, 64'(grant_id), 64'(e.id));
            chk({tag, "_upp"},   64'(use_provided_param), 64'd1);
            chk({tag, "_addr"},  provided_parameters_address, e.addr);
            chk({tag, "_len"},   64'(provided_parameters_length), 64'(e.len));
            chk({tag, "_type"},  64'(provided_request_type_r), 64'(e.typ));
        end
    endtask

    // Complete the in-flight transaction after `delay` cycles and check req_done.
    task automatic complete_after(input string tag, input int delay, input int id);
        for (int c = 1; c < delay; c++) tick();
        transaction_request_complete = 1'b1;
        tick();
        transaction_request_complete = 1'b0;
        chk({tag, "_done"},  64'(req_done), 64'(N'(1) << id));
        chk({tag, "_err"},   64'(req_error), 64'd0);
        tick();
        chk({tag, "_done_pulse"}, 64'(req_done), 64'd0);
    endtask

    initial begin
        req_valid = '0;
        transactor_request_busy = 1'b0;
        transaction_request_complete = 1'b0;
        for (int i = 0; i < N; i++) begin
            addr_t[i] = 64'h2000 + 64'(i) * 64'h100;
            len_t[i]  = 36'h10 + 36'(i);
            typ_t[i]  = 4'(i + 1);
        end

        // Reset state
        do_reset();
        chk("rst_busy",   64'(busy), 64'd0);
        chk("rst_grant",  64'(grant_id), 64'd0);
        chk("rst_accept", 64'(req_accept), 64'd0);
        chk("rst_done",   64'(req_done), 64'd0);
        chk("rst_treq",   64'(transactor_request), 64'd0);
        chk("rst_paddr",  provided_parameters_address, 64'd0);

        // 1: single request, exact latencies
        addr_t[0] = 64'h1000;
        len_t[0]  = 36'h100;
        typ_t[0]  = 4'h3;
        push_exp(0);
        req_valid = 4'b0001;
        tick();
        chk("t1_accept", 64'(req_accept), 64'b0001);
        chk("t1_busy",   64'(busy), 64'd1);
        chk("t1_no_treq_early", 64'(transactor_request), 64'd0);
        req_valid = '0;
        tick();
        begin
            exp_t e;
            e = sb.pop_front();
            chk("t1_treq",  64'(transactor_request), 64'd1);
            chk("t1_addr",  provided_parameters_address, e.addr);
            chk("t1_len",   64'(provided_parameters_length), 64'(e.len));
            chk("t1_type",  64'(provided_request_type_r), 64'(e.typ));
        end
        tick();
        chk("t1_treq_pulse", 64'(transactor_request), 64'd0);
        chk("t1_paddr_zero", provided_parameters_address, 64'd0);
        complete_after("t1", 1, 0);
        chk("t1_idle", 64'(busy), 64'd0);

        // 2: all four requesting continuously -> round-robin 0,1,2,3,0
        addr_t[0] = 64'h2000;
        len_t[0]  = 36'h10;
        typ_t[0]  = 4'h1;
        do_reset();
        push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_issue($sformatf("t2_g%0d", k), 1'b1);
            complete_after($sformatf("t2_g%0d", k), 5, (k == 4) ? 0 : k);
        end
        req_valid = '0;
        tick();
        tick();

        // 3: transactor busy holds the request in ST_ISSUE
        do_reset();
        transactor_request_busy = 1'b1;
        push_exp(1);
        req_valid = 4'b0010;
        tick();
        chk("t3_accept", 64'(req_accept), 64'b0010);
        req_valid = '0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("t3_hold%0d", c), 64'(transactor_request), 64'd0);
        end
        transactor_request_busy = 1'b0;
        wait_issue("t3", 1'b0);
        tick();
        chk("t3_single", 64'(transactor_request), 64'd0);
        complete_after("t3", 2, 1);

        // 4: zero-length request completes without a transactor pulse
        len_t[2] = 36'h0;
        req_valid = 4'b0100;
        tick();
        chk("t4_accept", 64'(req_accept), 64'b0100);
        chk("t4_treq_a", 64'(transactor_request), 64'd0);
        req_valid = '0;
        tick();
        chk("t4_done", 64'(req_done), 64'b0100);
        chk("t4_treq_b", 64'(transactor_request), 64'd0);
        tick();
        chk("t4_treq_c", 64'(transactor_request), 64'd0);
        chk("t4_idle",   64'(busy), 64'd0);
        len_t[2] = 36'h12;

        // 5: reset in ST_WAIT_DONE abandons the transaction
        push_exp(0);
        req_valid = 4'b0001;
        wait_issue("t5_pre", 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy",  64'(busy), 64'd0);
        chk("t5_done",  64'(req_done), 64'd0);
        chk("t5_treq",  64'(transactor_request), 64'd0);
        chk("t5_grant", 64'(grant_id), 64'd0);
        transaction_request_complete = 1'b1;
        tick();
        transaction_request_complete = 1'b0;
        chk("t5_ign_done", 64'(req_done), 64'd0);
        chk("t5_ign_busy", 64'(busy), 64'd0);
        push_exp(0);
        req_valid = 4'b1111;
        wait_issue("t5_post", 1'b0);
        req_valid = '0;
        complete_after("t5_post", 3, 0);

        // 6: no completion -> watchdog abort, or indefinite wait
        push_exp(0);
        req_valid = 4'b0001;
        wait_issue("t6", 1'b0);
`ifdef MASTER_ARB_TIMEOUT_EN
        for (int c = 1; c < TO; c++) begin
            tick();
            chk($sformatf("t6_wait%0d", c), 64'(req_done), 64'd0);
        end
        tick();
        chk("t6_to_done", 64'(req_done), 64'b0001);
        chk("t6_to_err",  64'(req_error), 64'd1);
        tick();
        chk("t6_to_idle", 64'(busy), 64'd0);
`else
        for (int c = 0; c < TO + 4; c++) tick();
        chk("t6_still_busy", 64'(busy), 64'd1);
        chk("t6_no_done",    64'(req_done), 64'd0);
        complete_after("t6", 1, 0);
`endif

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
